counter_sweep_arbiter: RTL
==========================

# counter_sweep_arbiter

Two-requester round-robin sequencer for the 10-to-40 wrapping up/down counter. It grants one requester at a time and loads that requester's start value into the counter. It then steps the counter a requested number of times in the requested direction, and freezes the counter between sweeps by continuous reload. It sits between software-facing request logic and the counter's `load`/`u_d`/`data` pins, and keeps an internal shadow of the expected count.

## Interface
Parameters:
- `LEN_W`, default 6: width of each sweep-length field.

Ports (clock and reset first):
- `clk` in 1: clock; all state changes on posedge.
- `rst` in 1: synchronous, active-low reset.
- `req` in 2: request per requester; must be held until that requester's `done` pulse.
- `req_start` in 16: start values; [7:0] for requester 0, [15:8] for requester 1.
- `req_len` in 2*LEN_W: step counts; [LEN_W-1:0] for requester 0.
- `req_dir` in 2: 1 = up, 0 = down, per requester.
- `gnt` out 2: one-hot grant, held LOAD through DONE.
- `done` out 2: one-cycle completion pulse for the granted requester.
- `err` out 1: one-cycle pulse with `done` when the start value is outside 10..40.
- `busy` out 1: high in any state except IDLE.
- `cnt_load` out 1: drives counter `load`.
- `cnt_u_d` out 1: drives counter `u_d`.
- `cnt_data` out 8: drives counter `data`.
- `cnt_count` in 8: counter `count` output.
- `chk_err` out 1: sticky count-mismatch flag (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, DONE, plus REJ for a rejected request.
- Shadow `exp` (8b) tracks the expected counter value.
- Hold behaviour: in IDLE and DONE, `cnt_load`=1 and `cnt_data`=`exp`, so the counter holds its value.
- IDLE:
  - No `req`: stay in IDLE.
  - Any `req` set: select the winner by round-robin. Pointer `last` holds the last granted index; the requester other than `last` wins ties.
  - Winner's start in 10..40: latch start/len/dir, set `gnt`, go to LOAD.
  - Winner's start outside 10..40: set `gnt`, go to REJ.
- REJ (1 cycle): `done`=1 and `err`=1, hold continues, `exp` is unchanged. Next state IDLE, `gnt` cleared, `last` updated.
- LOAD (1 cycle): `cnt_load`=1, `cnt_data`=start, `exp`<=start, step counter <= len.
  - len=0: go to DONE.
  - Otherwise: go to RUN.
- RUN: `cnt_load`=0 and `cnt_u_d`=dir. Each cycle the step counter decrements and `exp` is updated.
  - Up: `exp`<= (`exp`>=40) ? 10 : `exp`+1.
  - Down: `exp`<= (`exp`<=10) ? 40 : `exp`-1.
  - Leaves for DONE on the cycle the step counter reaches 1.
- DONE (1 cycle): `done[g]`=1, hold continues. Next state IDLE, `gnt` cleared, `last`<=g.
- Arithmetic: all values are unsigned 8-bit; the step counter is LEN_W bits; max sweep 2^LEN_W-1 steps.
- Request withdrawn mid-sweep: ignored. The sweep completes and `done` still pulses.
- A new `req` during a sweep is not sampled until IDLE.
- Back-to-back requests from the same requester are allowed. With both requesters requesting, grants alternate 0,1,0,1.

## Timing
- Reset (rst=0 at a posedge), next cycle:
  - state IDLE, `gnt`=0, `done`=0, `err`=0, `busy`=0, `chk_err`=0.
  - `exp`=10, `cnt_load`=1, `cnt_data`=10, `cnt_u_d`=0.
  - `last`=1, so requester 0 wins the first tie.
- Reset mid-sweep aborts immediately with the values above. No `done` is issued.
- Latency for `req` sampled at edge k:
  - LOAD runs in cycle k..k+1; the counter loads at edge k+1.
  - Counter steps occur at edges k+2..k+1+len.
  - DONE runs in cycle k+1+len..k+2+len; the next grant is possible at edge k+3+len.
  - len=0: DONE runs in cycle k+1..k+2.
- All outputs are decoded from registered state and registered data. There is no combinational path from `cnt_count` or `req` to any output.

## Configuration
- Macro `SWEEP_COUNT_CHECK_EN`.
- Defined: in every RUN and DONE cycle, compare `cnt_count` against `exp` (the value the counter should currently hold). On mismatch, set `chk_err`, which stays set until reset.
- Undefined: comparator is absent, `chk_err` is tied to 0, and the `cnt_count` input is unused.

## Test plan
- Reset, then idle 5 cycles -> `busy`=0, `cnt_load`=1, `cnt_data`=10, `gnt`=00, `chk_err`=0.
- req0, start=38, dir=up, len=5 -> LOAD drives `cnt_data`=38; RUN drives `cnt_u_d`=1 for 5 cycles; `exp` runs 39,40,10,11,12. In DONE, `done`=01 and `cnt_data`=12.
- req1, start=11, dir=down, len=3 -> `exp` runs 10,40,39; `done`=10 pulse; hold value 39.
- Both `req` held, each with len=2 -> grants 01,10,01,10 with one IDLE cycle between sweeps, 5 cycles per sweep.
- req0, start=9 -> REJ with `done`=01 and `err`=1 for one cycle, no `cnt_load` of 9, hold stays at the previous `exp`. Repeat with start=41 -> same response.
- With `SWEEP_COUNT_CHECK_EN` defined: force `cnt_count` wrong for 1 RUN cycle -> `chk_err`=1 and it stays 1 until rst=0. Reset mid-RUN -> no `done` pulse and outputs return to reset values.

Source files
------------

// File: rtl/counter_sweep_arbiter_if.sv
// Request-side bundle for counter_sweep_arbiter.
// The master side is software-facing request logic; the slave side is the arbiter.
interface counter_sweep_arbiter_if #(
    parameter int LEN_W = 6
);
    logic [1:0]         req;
    logic [15:0]        req_start;
    logic [2*LEN_W-1:0] req_len;
    logic [1:0]         req_dir;
    logic [1:0]         gnt;
    logic [1:0]         done;
    logic               err;
    logic               busy;

    modport master (
        output req, req_start, req_len, req_dir,
        input  gnt, done, err, busy
    );

    modport slave (
        input  req, req_start, req_len, req_dir,
        output gnt, done, err, busy
    );
endinterface

// File: rtl/counter_sweep_arbiter.sv
// Round-robin sweep sequencer for the 10..40 wrapping up/down counter.
// Optional macro SWEEP_COUNT_CHECK_EN adds the count-mismatch checker.
module counter_sweep_arbiter #(
    parameter int LEN_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    counter_sweep_arbiter_if.slave  bus,
    output logic                    cnt_load,
    output logic                    cnt_u_d,
    output logic [7:0]              cnt_data,
    input  logic [7:0]              cnt_count,
    output logic                    chk_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        REJ  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             last;
    logic             gidx;
    logic             dir_q;
    logic [7:0]       start_q;
    logic [7:0]       exp_q;
    logic [LEN_W-1:0] steps;

    logic             win;
    logic [7:0]       win_start;
    logic [LEN_W-1:0] win_len;
    logic             win_ok;
    logic [1:0]       g_oh;

    // The requester that was not granted last wins a tie.
    always_comb begin
        win       = (bus.req == 2'b11) ? ~last : bus.req[1];
        win_start = win ? bus.req_start[15:8] : bus.req_start[7:0];
        win_len   = win ? bus.req_len[2*LEN_W-1:LEN_W]
                        : bus.req_len[LEN_W-1:0];
        win_ok    = (win_start >= 8'd10) && (win_start <= 8'd40);
        g_oh      = gidx ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (|bus.req) state_nx = win_ok ? LOAD : REJ;
            LOAD: state_nx = (steps == '0) ? DONE : RUN;
            RUN:  if (steps == LEN_W'(1)) state_nx = DONE;
            DONE: state_nx = IDLE;
            REJ:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last    <= 1'b1;
            gidx    <= 1'b0;
            dir_q   <= 1'b0;
            start_q <= 8'd10;
            exp_q   <= 8'd10;
            steps   <= '0;
        end else begin
            unique case (state)
                IDLE: if (|bus.req) begin
                    gidx    <= win;
                    start_q <= win_start;
                    steps   <= win_len;
                    dir_q   <= bus.req_dir[win];
                end
                LOAD: exp_q <= start_q;
                RUN: begin
                    steps <= steps - 1'b1;
                    if (dir_q)
                        exp_q <= (exp_q >= 8'd40) ? 8'd10 : exp_q + 8'd1;
                    else
                        exp_q <= (exp_q <= 8'd10) ? 8'd40 : exp_q - 8'd1;
                end
                DONE: last <= gidx;
                REJ:  last <= gidx;
                default: ;
            endcase
        end
    end

    // Outside RUN the counter is continuously reloaded, so it holds exp.
    always_comb begin
        bus.gnt  = 2'b00;
        bus.done = 2'b00;
        bus.err  = 1'b0;
        bus.busy = (state != IDLE);
        cnt_load = 1'b1;
        cnt_u_d  = 1'b0;
        cnt_data = exp_q;
        unique case (state)
            IDLE: ;
            LOAD: begin
                bus.gnt  = g_oh;
                cnt_data = start_q;
            end
            RUN: begin
                bus.gnt  = g_oh;
                cnt_load = 1'b0;
                cnt_u_d  = dir_q;
            end
            DONE: begin
                bus.gnt  = g_oh;
                bus.done = g_oh;
            end
            REJ: begin
                bus.gnt  = g_oh;
                bus.done = g_oh;
                bus.err  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SWEEP_COUNT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst)
            chk_err <= 1'b0;
        else if ((state == RUN || state == DONE) && cnt_count != exp_q)
            chk_err <= 1'b1;
    end
`else
    logic unused_count;
    assign unused_count = ^cnt_count;
    assign chk_err      = 1'b0;
`endif

endmodule
